// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register file.
package apb_pkg;

  // Completer transfer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_e;

  // Bytes per register word and byte-offset bits stripped from PADDR
  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/apb_regfile.sv
// Byte-strobed register storage. Index 0 has no storage and reads back
// the constant ID; out-of-range read indices return 0.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = 6,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  // Strobed byte-lane writes; every lane with its strobe clear keeps its value
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (int'(wr_idx) == i) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) mem[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Combinational read port with the ID constant muxed in at index 0
  always_comb begin
    rd_data = '0;
    if (rd_idx == '0) rd_data = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(rd_idx) == i) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer in front of a byte-strobed register file. Latches the
// request in the setup phase, holds PREADY low for WAIT_CYCLES access
// cycles, then completes with registered PREADY/PRDATA/PSLVERR.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int         IDX_W     = ADDR_WIDTH - ADDR_LSB;
  localparam int         NB        = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_slv_state_e        state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      lat_idx;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [NB-1:0]         lat_strb;
  logic                  lat_err;

  logic                  setup;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;

  // Setup-phase decode straight off the bus: misaligned, out of range,
  // or a write to the read-only ID register is an error
  always_comb begin
    setup     = PSEL && !PENABLE;
    setup_idx = PADDR[ADDR_WIDTH-1:ADDR_LSB];
    setup_err = (PADDR[ADDR_LSB-1:0] != '0)
             || (int'(setup_idx) >= NUM_REGS)
             || (PWRITE && (setup_idx == '0));
  end

  // With zero wait states RESP is entered from IDLE, so the read port must
  // look at the live address; otherwise it looks at the latched one
  always_comb begin
    rd_idx = (state == IDLE) ? setup_idx : lat_idx;
    wr_en  = (state == RESP) && PSEL && lat_write && !lat_err;
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regs (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx),
    .wr_data (lat_wdata),
    .wr_strb (lat_strb),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Transfer FSM with registered completion outputs (zero unless completing)
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      lat_err   <= 1'b0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      case (state)
        IDLE: begin
          if (setup) begin
            lat_idx   <= setup_idx;
            lat_write <= PWRITE;
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
            lat_err   <= setup_err;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end else begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= setup_err;
              PRDATA  <= (setup_err || PWRITE) ? '0 : rd_data;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            // Requester walked away: discard the transfer
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state   <= RESP;
            cnt     <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= lat_err;
            PRDATA  <= (lat_err || lat_write) ? '0 : rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Write commit happens through wr_en on this edge
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench: one completer with no wait states, one with three.
module tb_apb_completer_regfile;

  logic             PCLK = 1'b0;
  logic [1:0]       rst_n;
  logic [1:0][7:0]  paddr;
  logic [1:0]       psel, penable, pwrite;
  logic [1:0][31:0] pwdata;
  logic [1:0][3:0]  pstrb;
  logic [1:0][31:0] prdata;
  logic [1:0]       pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_completer_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(rst_n[0]), .PADDR(paddr[0]), .PSEL(psel[0]),
    .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
    .PSTRB(pstrb[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]));

  apb_completer_regfile #(.WAIT_CYCLES(3)) u_dut1 (
    .PCLK(PCLK), .PRESETn(rst_n[1]), .PADDR(paddr[1]), .PSEL(psel[1]),
    .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
    .PSTRB(pstrb[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic outs_zero(input int u, input string tag);
    chk({tag, "_pready"},  {31'b0, pready[u]},  32'd0);
    chk({tag, "_prdata"},  prdata[u],           32'd0);
    chk({tag, "_pslverr"}, {31'b0, pslverr[u]}, 32'd0);
  endtask

  // Setup phase then first access cycle; returns at the access-cycle negedge
  task automatic start(input int u, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(negedge PCLK);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
    paddr[u] = a; pwdata[u] = d; pstrb[u] = s;
    @(negedge PCLK);
    penable[u] = 1'b1;
  endtask

  // Full transfer; leaves PSEL high so a following call is back-to-back
  task automatic xfer(input int u, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int waits);
    start(u, wr, a, d, s);
    waits = 0;
    while (!pready[u] && waits < 40) begin
      chk("wait_prdata",  prdata[u],           32'd0);
      chk("wait_pslverr", {31'b0, pslverr[u]}, 32'd0);
      @(negedge PCLK);
      waits++;
    end
    if (!pready[u]) chk("pready_timeout", {31'b0, pready[u]}, 32'd1);
    rd = prdata[u];
    er = pslverr[u];
  endtask

  task automatic bus_idle(input int u);
    @(negedge PCLK);
    psel[u] = 1'b0; penable[u] = 1'b0;
  endtask

  // Read expecting data, no error and the given wait count
  task automatic rd_ok(input int u, input logic [7:0] a, input logic [31:0] exp,
                       input int exp_w, input string tag);
    logic [31:0] rd; logic er; int w;
    xfer(u, 1'b0, a, 32'h0, 4'h0, rd, er, w);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"},  {31'b0, er}, 32'd0);
    chk({tag, "_wait"}, w, exp_w);
  endtask

  // Any transfer, checking completion data and error flag
  task automatic xf_chk(input int u, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    logic [31:0] rd; logic er; int w;
    xfer(u, wr, a, d, s, rd, er, w);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"},  {31'b0, er}, {31'b0, exp_e});
  endtask

  initial begin
    rst_n = 2'b00; psel = '0; penable = '0; pwrite = '0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge PCLK);
    outs_zero(0, "rst0");
    outs_zero(1, "rst1");
    rst_n = 2'b11;

    // ---- zero wait states ----
    begin
      logic [31:0] rd; logic er; int w;
      xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, w);
      chk("w04_wait", w, 0);
      chk("w04_err",  {31'b0, er}, 32'd0);
      chk("w04_data", rd, 32'd0);
    end
    rd_ok(0, 8'h04, 32'hDEADBEEF, 0, "r04");
    xf_chk(0, 1'b1, 8'h08, 32'h11223344, 4'b0101, 32'h0, 1'b0, "w08_strb");
    rd_ok(0, 8'h08, 32'h00220044, 0, "r08");
    rd_ok(0, 8'h00, 32'hA5B00001, 0, "rid");
    xf_chk(0, 1'b1, 8'h00, 32'h0BADF00D, 4'hF, 32'h0, 1'b1, "wid");
    rd_ok(0, 8'h00, 32'hA5B00001, 0, "rid2");
    xf_chk(0, 1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1, "r40_oor");
    xf_chk(0, 1'b0, 8'h06, 32'h0, 4'h0, 32'h0, 1'b1, "r06_mis");
    xf_chk(0, 1'b1, 8'h06, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "w06_mis");
    xf_chk(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "w40_oor");
    xf_chk(0, 1'b1, 8'h04, 32'h12345678, 4'h0, 32'h0, 1'b0, "w04_nostrb");
    rd_ok(0, 8'h04, 32'hDEADBEEF, 0, "r04_keep");
    rd_ok(0, 8'h08, 32'h00220044, 0, "r08_keep");
    // drop PSEL during the completion cycle of a write: no commit
    start(0, 1'b1, 8'h10, 32'hAAAA5555, 4'hF);
    chk("ab0_pready", {31'b0, pready[0]}, 32'd1);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    outs_zero(0, "ab0_after");
    rd_ok(0, 8'h10, 32'h0, 0, "r10_ab0");
    // reset during the completion cycle: outputs clear at once, no commit
    start(0, 1'b1, 8'h10, 32'h55555555, 4'hF);
    rst_n[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    #1;
    outs_zero(0, "mrst0");
    @(negedge PCLK);
    rst_n[0] = 1'b1;
    rd_ok(0, 8'h10, 32'h0, 0, "r10_rst0");
    rd_ok(0, 8'h04, 32'h0, 0, "r04_rst0");
    bus_idle(0);

    // ---- three wait states ----
    begin
      logic [31:0] rd; logic er; int w;
      xfer(1, 1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, rd, er, w);
      chk("w0c_wait", w, 3);
      chk("w0c_err",  {31'b0, er}, 32'd0);
    end
    rd_ok(1, 8'h0C, 32'hCAFEF00D, 3, "r0c_b2b");
    // drop PSEL in WAIT
    start(1, 1'b1, 8'h10, 32'h12345678, 4'hF);
    outs_zero(1, "ab1_wait");
    @(negedge PCLK);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) @(negedge PCLK);
    outs_zero(1, "ab1_after");
    rd_ok(1, 8'h10, 32'h0, 3, "r10_ab1");
    // reset during WAIT
    start(1, 1'b1, 8'h10, 32'h87654321, 4'hF);
    @(negedge PCLK);
    rst_n[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    #1;
    outs_zero(1, "mrst1");
    @(negedge PCLK);
    rst_n[1] = 1'b1;
    repeat (4) @(negedge PCLK);
    outs_zero(1, "mrst1_after");
    rd_ok(1, 8'h10, 32'h0, 3, "r10_rst1");
    rd_ok(1, 8'h0C, 32'h0, 3, "r0c_rst1");
    bus_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
